// File: rtl/inst_sram_responder_if.sv
// Instruction-fetch SRAM bus between the fetch stage (master) and the memory responder (slave).
// Carries request fields in and registered read data back.
interface inst_sram_responder_if;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport master (
        output sram_en, sram_wen, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport slave (
        input  sram_en, sram_wen, sram_addr, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/inst_sram_responder.sv
// Behavioural single-port instruction SRAM with kseg0/kseg1 translation, access counters and a sticky range error.
// Latency: one cycle from sampled request to registered sram_rdata; no backpressure, accepts a request every cycle.
// Backpressure: none -- the requester may issue back-to-back accesses; sram_en=0 holds sram_rdata.
module inst_sram_responder #(
    parameter int          DEPTH_LOG2 = 14,
    parameter logic [31:0] BASE_PADDR = 32'h1fc00000,
    parameter int          WRITE_MODE = 0
) (
    input  logic                        clk,
    input  logic                        resetn,
    inst_sram_responder_if.slave        sram,
    output logic [31:0]                 rd_cnt,
    output logic [31:0]                 wr_cnt,
    output logic                        err,
    output logic [31:0]                 err_addr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           paddr;
    logic [31:0]           off;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;
    logic                  is_wr;
    logic                  acc_ok;
    logic [31:0]           old_word;
    logic [31:0]           merged;
    logic                  unused_low_bits;

    // kseg0/kseg1 both map onto the low 512 MiB of physical space
    assign paddr           = {3'b000, sram.sram_addr[28:0]};
    assign off             = paddr - BASE_PADDR;
    assign idx             = off[DEPTH_LOG2+1:2];
    assign in_range        = (off[31:DEPTH_LOG2+2] == '0);
    assign is_wr           = (sram.sram_wen != 4'h0);
    assign acc_ok          = sram.sram_en && in_range;
    assign old_word        = mem[idx];
    assign unused_low_bits = ^off[1:0];

    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (sram.sram_wen[i]) begin
                merged[8*i +: 8] = sram.sram_wdata[8*i +: 8];
            end
        end
    end

    // Array is deliberately not reset; a write in a reset cycle is dropped
    always_ff @(posedge clk) begin
        if (resetn && acc_ok && is_wr) begin
            mem[idx] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sram.sram_rdata <= 32'h0;
            rd_cnt          <= 32'h0;
            wr_cnt          <= 32'h0;
            err             <= 1'b0;
            err_addr        <= 32'h0;
        end else if (sram.sram_en) begin
            if (in_range) begin
                sram.sram_rdata <= (WRITE_MODE != 0) ? merged : old_word;
                if (is_wr) begin
                    if (wr_cnt != 32'hffffffff) wr_cnt <= wr_cnt + 32'd1;
                end else begin
                    if (rd_cnt != 32'hffffffff) rd_cnt <= rd_cnt + 32'd1;
                end
            end else begin
                sram.sram_rdata <= 32'h0;
                if (!err) begin
                    err      <= 1'b1;
                    err_addr <= sram.sram_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Directed bench driving a read-first and a write-first responder with identical traffic.
module tb_inst_sram_responder;
    logic        clk;
    logic        resetn;
    logic [31:0] rd_cnt_a, wr_cnt_a, err_addr_a;
    logic [31:0] rd_cnt_b, wr_cnt_b, err_addr_b;
    logic        err_a, err_b;
    int          errors;
    int          checks;

    inst_sram_responder_if ifa ();
    inst_sram_responder_if ifb ();

    inst_sram_responder #(.DEPTH_LOG2(14), .BASE_PADDR(32'h1fc00000), .WRITE_MODE(0)) dut_a (
        .clk(clk), .resetn(resetn), .sram(ifa.slave),
        .rd_cnt(rd_cnt_a), .wr_cnt(wr_cnt_a), .err(err_a), .err_addr(err_addr_a)
    );

    inst_sram_responder #(.DEPTH_LOG2(14), .BASE_PADDR(32'h1fc00000), .WRITE_MODE(1)) dut_b (
        .clk(clk), .resetn(resetn), .sram(ifb.slave),
        .rd_cnt(rd_cnt_b), .wr_cnt(wr_cnt_b), .err(err_b), .err_addr(err_addr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        ifa.sram_en = en; ifa.sram_wen = wen; ifa.sram_addr = addr; ifa.sram_wdata = wdata;
        ifb.sram_en = en; ifb.sram_wen = wen; ifb.sram_addr = addr; ifb.sram_wdata = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        checks++;
        if (ifa.sram_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected %h", ifa.sram_rdata, 32'h0);
        end
        checks++;
        if (rd_cnt_a !== 32'h0 || wr_cnt_a !== 32'h0) begin
            errors++; $display("FAIL reset_cnt: got rd=%h wr=%h expected 0/0", rd_cnt_a, wr_cnt_a);
        end
        checks++;
        if (err_a !== 1'b0 || err_addr_a !== 32'h0) begin
            errors++; $display("FAIL reset_err: got err=%b addr=%h expected 0/0", err_a, err_addr_a);
        end
        resetn = 1'b1;
    endtask

    task automatic test_read();
        drive(1'b1, 4'hf, 32'hbfc00000, 32'h3c080001);
        drive(1'b1, 4'h0, 32'hbfc00000, 32'h0);
        checks++;
        if (ifa.sram_rdata !== 32'h3c080001) begin
            errors++; $display("FAIL read_data: got %h expected %h", ifa.sram_rdata, 32'h3c080001);
        end
        checks++;
        if (rd_cnt_a !== 32'd1 || wr_cnt_a !== 32'd1) begin
            errors++; $display("FAIL read_cnt: got rd=%0d wr=%0d expected 1/1", rd_cnt_a, wr_cnt_a);
        end
    endtask

    task automatic test_byte_write();
        drive(1'b1, 4'hf, 32'h9fc00004, 32'h11223344);
        drive(1'b1, 4'b0101, 32'h9fc00004, 32'haabbccdd);
        checks++;
        if (ifa.sram_rdata !== 32'h11223344) begin
            errors++; $display("FAIL wr_rdata_readfirst: got %h expected %h", ifa.sram_rdata, 32'h11223344);
        end
        checks++;
        if (ifb.sram_rdata !== 32'h11bb33dd) begin
            errors++; $display("FAIL wr_rdata_writefirst: got %h expected %h", ifb.sram_rdata, 32'h11bb33dd);
        end
        drive(1'b1, 4'h0, 32'h9fc00004, 32'h0);
        checks++;
        if (ifa.sram_rdata !== 32'h11bb33dd || ifb.sram_rdata !== 32'h11bb33dd) begin
            errors++; $display("FAIL byte_merge: got a=%h b=%h expected %h", ifa.sram_rdata, ifb.sram_rdata, 32'h11bb33dd);
        end
        checks++;
        if (wr_cnt_a !== 32'd3 || rd_cnt_a !== 32'd2) begin
            errors++; $display("FAIL byte_cnt: got rd=%0d wr=%0d expected 2/3", rd_cnt_a, wr_cnt_a);
        end
    endtask

    task automatic test_idle();
        drive(1'b1, 4'h0, 32'hbfc00000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'hf, 32'hbfc00000, 32'hdeadbeef);
            checks++;
            if (ifa.sram_rdata !== 32'h3c080001) begin
                errors++; $display("FAIL idle_hold: got %h expected %h", ifa.sram_rdata, 32'h3c080001);
            end
        end
        checks++;
        if (rd_cnt_a !== 32'd3 || wr_cnt_a !== 32'd3) begin
            errors++; $display("FAIL idle_cnt: got rd=%0d wr=%0d expected 3/3", rd_cnt_a, wr_cnt_a);
        end
        drive(1'b1, 4'h0, 32'hbfc00000, 32'h0);
        checks++;
        if (ifa.sram_rdata !== 32'h3c080001) begin
            errors++; $display("FAIL idle_nowrite: got %h expected %h", ifa.sram_rdata, 32'h3c080001);
        end
    endtask

    task automatic test_out_of_range();
        drive(1'b1, 4'h0, 32'hbfbffffc, 32'h0);
        checks++;
        if (ifa.sram_rdata !== 32'h0 || err_a !== 1'b1 || err_addr_a !== 32'hbfbffffc) begin
            errors++; $display("FAIL oor_below: got rdata=%h err=%b addr=%h expected 0/1/bfbffffc", ifa.sram_rdata, err_a, err_addr_a);
        end
        drive(1'b1, 4'h0, 32'hbfc0fffc, 32'h0);
        drive(1'b1, 4'h0, 32'hbfc10000, 32'h0);
        checks++;
        if (ifa.sram_rdata !== 32'h0 || err_addr_a !== 32'hbfbffffc) begin
            errors++; $display("FAIL oor_above: got rdata=%h addr=%h expected 0/bfbffffc", ifa.sram_rdata, err_addr_a);
        end
        drive(1'b1, 4'hf, 32'hbfc10000, 32'h12345678);
        checks++;
        if (rd_cnt_a !== 32'd5 || wr_cnt_a !== 32'd3 || err_b !== 1'b1) begin
            errors++; $display("FAIL oor_cnt: got rd=%0d wr=%0d errb=%b expected 5/3/1", rd_cnt_a, wr_cnt_a, err_b);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) drive(1'b1, 4'hf, 32'hbfc00000 + 32'(4*k), 32'h10000000 + 32'(k));
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 4'h0, 32'hbfc00000 + 32'(4*k), 32'h0);
            checks++;
            if (ifa.sram_rdata !== 32'h10000000 + 32'(k)) begin
                errors++; $display("FAIL stream_word%0d: got %h expected %h", k, ifa.sram_rdata, 32'h10000000 + 32'(k));
            end
        end
        checks++;
        if (rd_cnt_a !== 32'd13 || wr_cnt_a !== 32'd11 || rd_cnt_b !== 32'd13) begin
            errors++; $display("FAIL stream_cnt: got rd=%0d wr=%0d rdb=%0d expected 13/11/13", rd_cnt_a, wr_cnt_a, rd_cnt_b);
        end
    endtask

    task automatic test_reset_write();
        resetn = 1'b0;
        drive(1'b1, 4'hf, 32'hbfc00008, 32'hffffffff);
        checks++;
        if (rd_cnt_a !== 32'h0 || wr_cnt_a !== 32'h0 || ifa.sram_rdata !== 32'h0 || err_a !== 1'b0) begin
            errors++; $display("FAIL rstwr_state: got rd=%h wr=%h rdata=%h err=%b expected 0/0/0/0", rd_cnt_a, wr_cnt_a, ifa.sram_rdata, err_a);
        end
        resetn = 1'b1;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 4'h0, 32'hbfc00008, 32'h0);
        checks++;
        if (ifa.sram_rdata !== 32'h10000002 || rd_cnt_a !== 32'd1 || wr_cnt_a !== 32'd0) begin
            errors++; $display("FAIL rstwr_mem: got rdata=%h rd=%0d wr=%0d expected 10000002/1/0", ifa.sram_rdata, rd_cnt_a, wr_cnt_a);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        resetn = 1'b0;
        test_reset();
        test_read();
        test_byte_write();
        test_idle();
        test_out_of_range();
        test_back_to_back();
        test_reset_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
